// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: latches ALU results and memory/writeback controls,
// owns the architectural N/V/Z flags and a sticky halt.
module ex_mem_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [3:0]        ex_opcode,
    input  logic [DATA_W-1:0] ex_alu_out,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_halt,
    input  logic              ex_flag_we,
    input  logic              ex_n,
    input  logic              ex_v,
    input  logic              ex_z,
    output logic              mem_valid,
    output logic [3:0]        mem_opcode,
    output logic [DATA_W-1:0] mem_alu_out,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [REG_W-1:0]  mem_rd,
    output logic              mem_reg_write,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output logic              mem_fwd_en,
    output logic              flag_n,
    output logic              flag_v,
    output logic              flag_z,
    output logic              halted
);

    // Once halted, every unstalled edge behaves like a flush.
    logic bubble;
    assign bubble = flush || (!stall && halted);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid      <= 1'b0;
            mem_opcode     <= '0;
            mem_alu_out    <= '0;
            mem_store_data <= '0;
            mem_rd         <= '0;
            mem_reg_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            flag_n         <= 1'b0;
            flag_v         <= 1'b0;
            flag_z         <= 1'b0;
            halted         <= 1'b0;
        end else if (bubble) begin
            mem_valid     <= 1'b0;
            mem_reg_write <= 1'b0;
            mem_mem_read  <= 1'b0;
            mem_mem_write <= 1'b0;
        end else if (!stall) begin
            mem_valid      <= ex_valid;
            mem_opcode     <= ex_opcode;
            mem_alu_out    <= ex_alu_out;
            mem_store_data <= ex_store_data;
            mem_rd         <= ex_rd;
            mem_reg_write  <= ex_reg_write & ex_valid;
            mem_mem_read   <= ex_mem_read  & ex_valid;
            mem_mem_write  <= ex_mem_write & ex_valid;
            // ALU already merges unchanged flags, so all three are written together.
            if (ex_valid && ex_flag_we) begin
                flag_n <= ex_n;
                flag_v <= ex_v;
                flag_z <= ex_z;
            end
            if (ex_valid && ex_halt)
                halted <= 1'b1;
        end
    end

    assign mem_fwd_en = mem_valid & mem_reg_write & ~mem_mem_read;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0, flush = 1'b0;
    logic        ex_valid = 1'b0;
    logic [3:0]  ex_opcode = '0;
    logic [15:0] ex_alu_out = '0, ex_store_data = '0;
    logic [3:0]  ex_rd = '0;
    logic        ex_reg_write = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0;
    logic        ex_halt = 1'b0, ex_flag_we = 1'b0, ex_n = 1'b0, ex_v = 1'b0, ex_z = 1'b0;

    logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_fwd_en;
    logic [3:0]  mem_opcode, mem_rd;
    logic [15:0] mem_alu_out, mem_store_data;
    logic        flag_n, flag_v, flag_z, halted;

    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h4,
                           OP_LW = 4'h8, OP_SW = 4'h9, OP_HLT = 4'hF;

    ex_mem_stage #(.DATA_W(16), .REG_W(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_alu_out(ex_alu_out),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_halt(ex_halt),
        .ex_flag_we(ex_flag_we), .ex_n(ex_n), .ex_v(ex_v), .ex_z(ex_z),
        .mem_valid(mem_valid), .mem_opcode(mem_opcode), .mem_alu_out(mem_alu_out),
        .mem_store_data(mem_store_data), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_fwd_en(mem_fwd_en),
        .flag_n(flag_n), .flag_v(flag_v), .flag_z(flag_z), .halted(halted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Behavioural model: the MEM-side view of one instruction plus flags/halt.
    typedef struct packed {
        logic        valid;
        logic [3:0]  op;
        logic [15:0] alu;
        logic [15:0] sd;
        logic [3:0]  rd;
        logic        rw, mr, mw;
    } slot_t;
    slot_t      m_slot = '0;
    logic [2:0] m_flags = '0;   // {n,v,z}
    logic       m_halt = 1'b0;

    typedef enum {A_RESET, A_BUBBLE, A_HOLD, A_LOAD} act_e;

    always @(posedge clk or posedge rst) begin
        act_e a;
        if (rst)         a = A_RESET;
        else if (flush)  a = A_BUBBLE;
        else if (stall)  a = A_HOLD;
        else if (m_halt) a = A_BUBBLE;
        else             a = A_LOAD;
        case (a)
            A_RESET: begin m_slot <= '0; m_flags <= '0; m_halt <= 1'b0; end
            A_BUBBLE: begin
                m_slot.valid <= 1'b0;
                m_slot.rw <= 1'b0; m_slot.mr <= 1'b0; m_slot.mw <= 1'b0;
            end
            A_LOAD: begin
                m_slot <= '{valid: ex_valid, op: ex_opcode, alu: ex_alu_out, sd: ex_store_data,
                            rd: ex_rd, rw: ex_valid && ex_reg_write,
                            mr: ex_valid && ex_mem_read, mw: ex_valid && ex_mem_write};
                if (ex_valid && ex_flag_we) m_flags <= {ex_n, ex_v, ex_z};
                if (ex_valid && ex_halt)    m_halt <= 1'b1;
            end
            default: ;
        endcase
    end

    function automatic logic [63:0] dut_vec();
        return {15'd0, mem_valid, mem_opcode, mem_alu_out, mem_store_data, mem_rd,
                mem_reg_write, mem_mem_read, mem_mem_write, mem_fwd_en,
                flag_n, flag_v, flag_z, halted};
    endfunction

    function automatic logic [63:0] mdl_vec();
        logic fwd;
        fwd = m_slot.valid && m_slot.rw && !m_slot.mr;
        return {15'd0, m_slot.valid, m_slot.op, m_slot.alu, m_slot.sd, m_slot.rd,
                m_slot.rw, m_slot.mr, m_slot.mw, fwd, m_flags, m_halt};
    endfunction

    logic cmp_en = 1'b0;
    always @(negedge clk) if (cmp_en) chk("cycle", dut_vec(), mdl_vec());

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] alu, sd,
                         input logic [3:0] rd, input logic rw, mr, mw, h, fwe, n, vv, z);
        ex_valid = v; ex_opcode = op; ex_alu_out = alu; ex_store_data = sd; ex_rd = rd;
        ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; ex_halt = h;
        ex_flag_we = fwe; ex_n = n; ex_v = vv; ex_z = z;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 chk("reset_state", dut_vec(), 64'd0);
        step(); step();
        rst = 1'b0;
        cmp_en = 1'b1;

        // Asynchronous reset in the middle of a cycle.
        drive(1, OP_ADD, 16'h1234, 16'h0, 4'd2, 1, 0, 0, 0, 1, 1, 1, 0);
        step();
        chk("load_alu", {48'd0, mem_alu_out}, 64'h1234);
        chk("load_flags", {61'd0, flag_n, flag_v, flag_z}, 64'b110);
        #2 rst = 1'b1;
        #1 chk("async_reset", dut_vec(), 64'd0);
        step(); rst = 1'b0;

        // Flag write then flag-preserving LW; forwarding enable.
        drive(1, OP_ADD, 16'h0007, 16'h0, 4'd1, 1, 0, 0, 0, 1, 0, 1, 1);
        step();
        chk("flags_after_add", {61'd0, flag_n, flag_v, flag_z}, 64'b011);
        chk("fwd_add", {63'd0, mem_fwd_en}, 64'd1);
        drive(1, OP_LW, 16'h0040, 16'h0, 4'd5, 1, 1, 0, 0, 0, 1, 0, 0);
        step();
        chk("flags_after_lw", {61'd0, flag_n, flag_v, flag_z}, 64'b011);
        chk("fwd_lw", {63'd0, mem_fwd_en}, 64'd0);

        // Stall holds SUB while XOR waits in EX.
        drive(1, OP_SUB, 16'hFFFE, 16'h0, 4'd3, 1, 0, 0, 0, 1, 1, 0, 0);
        step();
        stall = 1'b1;
        drive(1, OP_XOR, 16'h00FF, 16'h1111, 4'd6, 1, 0, 0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_alu", {48'd0, mem_alu_out}, 64'hFFFE);
            chk("stall_flags", {61'd0, flag_n, flag_v, flag_z}, 64'b100);
        end
        stall = 1'b0;
        step();
        chk("unstall_alu", {48'd0, mem_alu_out}, 64'h00FF);
        chk("unstall_flags", {61'd0, flag_n, flag_v, flag_z}, 64'b001);

        // Flush wins over stall; store data keeps prior value.
        flush = 1'b1; stall = 1'b1;
        drive(1, OP_SW, 16'h0010, 16'hBEEF, 4'd0, 0, 0, 1, 0, 1, 1, 1, 1);
        step();
        chk("flush_valid", {62'd0, mem_valid, mem_mem_write}, 64'd0);
        chk("flush_sd", {48'd0, mem_store_data}, 64'h1111);
        chk("fwd_bubble", {63'd0, mem_fwd_en}, 64'd0);
        chk("flush_flags", {61'd0, flag_n, flag_v, flag_z}, 64'b001);

        // Flushed HLT is discarded.
        stall = 1'b0;
        drive(1, OP_HLT, 16'h0, 16'h0, 4'd0, 0, 0, 0, 1, 0, 0, 0, 0);
        step();
        chk("flush_hlt", {63'd0, halted}, 64'd0);
        flush = 1'b0;
        step();
        chk("hlt_enter", {61'd0, halted, mem_valid, mem_reg_write}, 64'b110);
        drive(1, OP_ADD, 16'h5555, 16'h0, 4'd7, 1, 0, 0, 0, 1, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halted_bubble", {61'd0, halted, mem_valid, mem_fwd_en}, 64'b100);
            chk("halted_flags", {61'd0, flag_n, flag_v, flag_z}, 64'b001);
        end
        #2 rst = 1'b1;
        #1 chk("halt_clear", {63'd0, halted}, 64'd0);
        step(); rst = 1'b0;

        // Randomized traffic, checked each cycle by the compare process.
        for (int c = 0; c < 3000; c++) begin
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 4) == 0);
            drive($urandom_range(0, 3) != 0, 4'($urandom), 16'($urandom), 16'($urandom),
                  4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 59) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom));
            if (c % 300 == 299) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
            step();
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline register directly downstream of the ALU in the 16-bit pipelined CPU.
- Captures the ALU result, store data, destination register and memory/writeback controls each cycle.
- Owns the architectural N/V/Z flag register. Flags are written from the ALU's flag outputs and fed back to the ALU flag inputs and to the ID-stage branch logic.
- Supports stall (hold) and flush (bubble insert), and tracks a sticky halt.

Parameters:
- DATA_W, 16, width of ALU result and store data.
- REG_W, 4, width of register specifiers.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold all stage state this cycle.
- flush  in  1  load a bubble this cycle (priority over stall).
- ex_valid  in  1  EX holds a real instruction.
- ex_opcode  in  4  instruction opcode from EX.
- ex_alu_out  in  DATA_W  ALU result or LW/SW address.
- ex_store_data  in  DATA_W  forwarded rt value for SW.
- ex_rd  in  REG_W  destination register.
- ex_reg_write  in  1  writeback enable.
- ex_mem_read  in  1  LW.
- ex_mem_write  in  1  SW.
- ex_halt  in  1  HLT instruction.
- ex_flag_we  in  1  ALU write_flag_en.
- ex_n, ex_v, ex_z  in  1 each  ALU next-flag values.
- mem_valid  out  1  MEM holds a real instruction.
- mem_opcode  out  4  registered opcode.
- mem_alu_out  out  DATA_W  registered ALU result / address.
- mem_store_data  out  DATA_W  registered store data.
- mem_rd  out  REG_W  registered destination.
- mem_reg_write, mem_mem_read, mem_mem_write  out  1 each  registered controls, gated by valid.
- mem_fwd_en  out  1  mem_valid & mem_reg_write & !mem_mem_read: mem_alu_out is forwardable to EX.
- flag_n, flag_v, flag_z  out  1 each  architectural flags.
- halted  out  1  sticky: a valid HLT has entered MEM.

Behaviour:
- Reset (async, rst=1): every registered output is 0, including mem_valid, all controls, data, mem_rd, flags and halted. Deassertion takes effect on the next clk edge.
- Per-edge priority:
  1. flush: bubble.
  2. else stall: hold.
  3. else halted: bubble.
  4. else load.
- Bubble:
  - mem_valid, mem_reg_write, mem_mem_read and mem_mem_write go to 0.
  - mem_opcode, data and rd hold their previous values.
  - No flag write.
- Hold: all stage registers and flags unchanged.
- Load:
  - All mem_* registers take their ex_* counterparts.
  - Controls are ANDed with ex_valid, so a load with ex_valid=0 behaves as a bubble for the control bits.
- Flag write:
  - Happens only on a load edge with ex_valid & ex_flag_we.
  - All three flags are written from ex_n/ex_v/ex_z. The ALU already passes through unchanged flags for partial-update opcodes, so this stage does not decode opcodes.
  - Flags written in cycle k are visible on flag_* from cycle k+1, i.e. the instruction immediately following sees them.
- Halt:
  - Set on a load edge with ex_valid & ex_halt.
  - The HLT itself enters MEM with mem_valid=1 and all controls 0.
  - Once set, halted remains 1 until rst. Every later non-stall, non-flush edge loads a bubble, and flags are frozen.
- Simultaneous events:
  - flush with a valid HLT: HLT discarded, halted unchanged.
  - flush with ex_flag_we: flags unchanged.
  - stall with halted=1: hold.
- mem_fwd_en is combinational from registered state only; there is no combinational path from ex_* inputs to any output.
- Latency: exactly one cycle from an EX input to the MEM output.

Test Plan:
- Reset mid-operation: load ADD with ex_alu_out=0x1234 and flags n=1,z=0,v=1; assert rst asynchronously between edges. All outputs read 0 immediately, before the next edge.
- Flag write/read: ADD, ex_flag_we=1, n=0 v=1 z=1. Next cycle flag_v=1, flag_z=1. Following LW with ex_flag_we=0 leaves flags unchanged.
- Stall: load SUB result 0xFFFE to rd=3, then hold stall=1 for 3 cycles while EX presents XOR 0x00FF with flag_we. mem_alu_out stays 0xFFFE, flags are unchanged, and XOR is captured on the first unstalled edge.
- Flush over stall: flush=1, stall=1 with a valid SW. mem_valid=0, mem_mem_write=0, and mem_store_data holds its prior value.
- Halt: valid HLT loads, so halted=1 and mem_valid=1 with reg_write=0. Subsequent valid ADD with flag_we produces mem_valid=0 and no flag change, and halted stays 1 until rst.
- Forwarding flag: valid ADD with reg_write=1 gives mem_fwd_en=1. Valid LW with reg_write=1 gives mem_fwd_en=0. A bubble gives mem_fwd_en=0.
